// File: rtl/block_interleaver_v2.sv
// Ping-pong ROWS x COLS block interleaver on AXI-Stream.
// The write side fills a bank linearly. The read side walks a full bank in row/col permuted order.
module block_interleaver_v2 #(
   parameter int DATA_W = 32,
   parameter int ROWS   = 4,
   parameter int COLS   = 65
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cfg_mode,
   input  logic [DATA_W-1:0] s_axis_tdata,
   input  logic              s_axis_tvalid,
   input  logic              s_axis_tlast,
   output logic              s_axis_tready,
   output logic [DATA_W-1:0] m_axis_tdata,
   output logic              m_axis_tvalid,
   output logic              m_axis_tlast,
   input  logic              m_axis_tready,
   output logic [1:0]        bank_full,
   output logic              err_tlast
);
   localparam int N  = ROWS * COLS;
   localparam int AW = $clog2(N);
   localparam logic [AW-1:0] W_LAST  = AW'(N - 1);
   localparam logic [AW-1:0] ROWS_M1 = AW'(ROWS - 1);
   localparam logic [AW-1:0] COLS_M1 = AW'(COLS - 1);
   localparam logic [AW-1:0] ROWS_ST = AW'(ROWS);
   localparam logic [AW-1:0] COLS_ST = AW'(COLS);

   logic [DATA_W-1:0] mem [2][N];
   logic [DATA_W-1:0] ram_data_q;

   logic [AW-1:0]     w_q, w_d;
   logic              wr_bank_q, wr_bank_d;
   logic              rd_bank_q, rd_bank_d;
   logic [1:0]        full_q, full_d;
   logic [1:0]        mode_q, mode_d;
   logic              err_q, err_d;
   logic [AW-1:0]     inner_q, inner_d, outer_q, outer_d, raddr_q, raddr_d;
   logic              ram_vld_q, ram_vld_d, ram_last_q, ram_last_d;
   logic [DATA_W-1:0] out_data_q, out_data_d, skid_data_q, skid_data_d;
   logic              out_vld_q, out_vld_d, out_last_q, out_last_d;
   logic              skid_vld_q, skid_vld_d, skid_last_q, skid_last_d;

   logic              acc, w_last, rmode, pop, issue, rd_last;
   logic [AW-1:0]     in_lim, out_lim, step;
   logic [1:0]        occ;

   assign s_axis_tready = rst_n && !full_q[wr_bank_q];
   assign m_axis_tdata  = out_data_q;
   assign m_axis_tvalid = out_vld_q;
   assign m_axis_tlast  = out_last_q;
   assign bank_full     = full_q;
   assign err_tlast     = err_q;

   always_comb begin
      acc     = s_axis_tvalid && s_axis_tready;
      w_last  = (w_q == W_LAST);
      rmode   = mode_q[rd_bank_q];
      in_lim  = rmode ? ROWS_M1 : COLS_M1;
      out_lim = rmode ? COLS_M1 : ROWS_M1;
      step    = rmode ? COLS_ST : ROWS_ST;
      pop     = out_vld_q && m_axis_tready;
      // Words in flight plus buffered, after this cycle's pop; one more read must still fit the skid.
      occ     = 2'(out_vld_q) + 2'(skid_vld_q) + 2'(ram_vld_q) - 2'(pop);
      issue   = full_q[rd_bank_q] && (occ <= 2'd1);
      rd_last = (inner_q == in_lim) && (outer_q == out_lim);

      w_d       = w_q;
      wr_bank_d = wr_bank_q;
      full_d    = full_q;
      mode_d    = mode_q;
      err_d     = 1'b0;
      if (acc) begin
         err_d = (s_axis_tlast != w_last);
         if (w_q == '0) mode_d[wr_bank_q] = cfg_mode;
         if (w_last) begin
            w_d               = '0;
            wr_bank_d         = !wr_bank_q;
            full_d[wr_bank_q] = 1'b1;
         end else begin
            w_d = w_q + 1'b1;
         end
      end

      rd_bank_d = rd_bank_q;
      inner_d   = inner_q;
      outer_d   = outer_q;
      raddr_d   = raddr_q;
      if (issue) begin
         if (rd_last) begin
            inner_d           = '0;
            outer_d           = '0;
            raddr_d           = '0;
            rd_bank_d         = !rd_bank_q;
            full_d[rd_bank_q] = 1'b0;
         end else if (inner_q == in_lim) begin
            inner_d = '0;
            outer_d = outer_q + 1'b1;
            raddr_d = outer_q + 1'b1;
         end else begin
            inner_d = inner_q + 1'b1;
            raddr_d = raddr_q + step;
         end
      end
      ram_vld_d  = issue;
      ram_last_d = issue && rd_last;

      out_vld_d   = out_vld_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      skid_vld_d  = skid_vld_q;
      skid_data_d = skid_data_q;
      skid_last_d = skid_last_q;
      if (pop) begin
         if (skid_vld_q) begin
            out_data_d = skid_data_q;
            out_last_d = skid_last_q;
            if (ram_vld_q) begin
               skid_data_d = ram_data_q;
               skid_last_d = ram_last_q;
            end else begin
               skid_vld_d = 1'b0;
            end
         end else if (ram_vld_q) begin
            out_data_d = ram_data_q;
            out_last_d = ram_last_q;
         end else begin
            out_vld_d = 1'b0;
         end
      end else if (ram_vld_q) begin
         if (!out_vld_q) begin
            out_vld_d  = 1'b1;
            out_data_d = ram_data_q;
            out_last_d = ram_last_q;
         end else begin
            skid_vld_d  = 1'b1;
            skid_data_d = ram_data_q;
            skid_last_d = ram_last_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (acc) mem[wr_bank_q][w_q] <= s_axis_tdata;
      if (issue) ram_data_q <= mem[rd_bank_q][raddr_q];
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         w_q         <= '0;
         wr_bank_q   <= 1'b0;
         rd_bank_q   <= 1'b0;
         full_q      <= '0;
         mode_q      <= '0;
         err_q       <= 1'b0;
         inner_q     <= '0;
         outer_q     <= '0;
         raddr_q     <= '0;
         ram_vld_q   <= 1'b0;
         ram_last_q  <= 1'b0;
         out_vld_q   <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         skid_vld_q  <= 1'b0;
         skid_data_q <= '0;
         skid_last_q <= 1'b0;
      end else begin
         w_q         <= w_d;
         wr_bank_q   <= wr_bank_d;
         rd_bank_q   <= rd_bank_d;
         full_q      <= full_d;
         mode_q      <= mode_d;
         err_q       <= err_d;
         inner_q     <= inner_d;
         outer_q     <= outer_d;
         raddr_q     <= raddr_d;
         ram_vld_q   <= ram_vld_d;
         ram_last_q  <= ram_last_d;
         out_vld_q   <= out_vld_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
         skid_vld_q  <= skid_vld_d;
         skid_data_q <= skid_data_d;
         skid_last_q <= skid_last_d;
      end
   end

endmodule

// File: tb/tb_block_interleaver_v2.sv
// Scoreboard bench for block_interleaver_v2 at ROWS=4, COLS=3.
module tb_block_interleaver_v2;
   localparam int R  = 4;
   localparam int C  = 3;
   localparam int NW = R * C;

   logic        clk = 1'b0;
   logic        rst_n, cfg_mode, s_tvalid, s_tlast, s_tready;
   logic [31:0] s_tdata, m_tdata;
   logic        m_tvalid, m_tlast, m_tready, err_tlast;
   logic [1:0]  bank_full;

   typedef struct {
      logic [31:0] d;
      logic        l;
   } exp_t;
   exp_t sb[$];

   int  n_chk = 0, n_err = 0, err_cnt = 0, n_xfer = 0, cyc = 0;
   int  first_cyc = -1, last_cyc = 0, t0 = 0;
   bit  fix_rdy = 1'b1, rnd_rdy = 1'b0, rnd_bit = 1'b0, hold_chk = 1'b0;
   logic [31:0] hold_d = '0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(posedge clk) begin
      #1;
      rnd_bit = 1'($urandom_range(0, 1));
   end
   assign m_tready = rnd_rdy ? rnd_bit : fix_rdy;

   block_interleaver_v2 #(.DATA_W(32), .ROWS(R), .COLS(C)) dut (
      .clk(clk), .rst_n(rst_n), .cfg_mode(cfg_mode),
      .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid), .s_axis_tlast(s_tlast), .s_axis_tready(s_tready),
      .m_axis_tdata(m_tdata), .m_axis_tvalid(m_tvalid), .m_axis_tlast(m_tlast), .m_axis_tready(m_tready),
      .bank_full(bank_full), .err_tlast(err_tlast)
   );

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   // Output monitor: scoreboard pop, stall stability, err pulse count.
   always @(negedge clk) begin
      exp_t e;
      if (rst_n) begin
         if (err_tlast) err_cnt++;
         if (hold_chk && m_tvalid) chk("hold_data", m_tdata, hold_d);
         hold_chk = m_tvalid && !m_tready;
         hold_d   = m_tdata;
         if (m_tvalid && m_tready) begin
            if (sb.size() == 0) chk("sb_empty", 32'd1, 32'd0);
            else begin
               e = sb.pop_front();
               chk("tdata", m_tdata, e.d);
               chk("tlast", 32'(m_tlast), 32'(e.l));
            end
            n_xfer++;
            if (first_cyc < 0) first_cyc = cyc;
            last_cyc = cyc;
         end
      end else begin
         hold_chk = 1'b0;
      end
   end

   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic m, input int base);
      int w;
      exp_t e;
      for (int r = 0; r < NW; r++) begin
         w = m ? (r % R) * C + r / R : (r % C) * R + r / C;
         e.d = 32'(base + w);
         e.l = (r == NW - 1);
         sb.push_back(e);
      end
   endtask

   task automatic drive_beat(input logic [31:0] d, input logic l, input logic m);
      bit done;
      int g;
      s_tdata = d; s_tlast = l; cfg_mode = m; s_tvalid = 1'b1;
      done = 1'b0; g = 0;
      while (!done) begin
         @(negedge clk);
         done = s_tready;
         cycle();
         g++;
         if (!done && g > 3000) begin
            chk("in_timeout", 32'd0, 32'd1);
            done = 1'b1;
         end
      end
      s_tvalid = 1'b0;
   endtask

   // Later beats drive random cfg_mode: only the first beat's mode may count.
   task automatic send_block(input logic m, input int base, input int nb, input bit rnd, input bit bad, input bit push);
      logic l;
      if (push) push_exp(m, base);
      for (int i = 0; i < nb; i++) begin
         while (rnd && $urandom_range(0, 1) == 1) cycle();
         l = bad ? (i == 5) : (i == NW - 1);
         drive_beat(32'(base + i), l, (i == 0) ? m : 1'($urandom_range(0, 1)));
      end
   endtask

   task automatic drain();
      int g;
      g = 0;
      while (sb.size() != 0 && g < 8000) begin
         cycle();
         g++;
      end
      chk("drain", 32'(sb.size()), 32'd0);
   endtask

   task automatic chk_reset(input string tag);
      chk({tag, "_s_tready"}, 32'(s_tready), 32'd0);
      chk({tag, "_m_tvalid"}, 32'(m_tvalid), 32'd0);
      chk({tag, "_m_tlast"}, 32'(m_tlast), 32'd0);
      chk({tag, "_m_tdata"}, m_tdata, 32'd0);
      chk({tag, "_bank_full"}, 32'(bank_full), 32'd0);
      chk({tag, "_err"}, 32'(err_tlast), 32'd0);
   endtask

   task automatic run_all();
      int g, n0, e0;
      rst_n = 1'b0; s_tvalid = 1'b0; s_tlast = 1'b0; s_tdata = '0; cfg_mode = 1'b0;
      repeat (3) cycle();
      chk_reset("rst");
      rst_n = 1'b1;
      cycle();

      // Mode 0 block with first-output latency measured from the bank_full edge.
      fork
         send_block(1'b0, 0, NW, 1'b0, 1'b0, 1'b1);
         begin
            g = 0;
            while (bank_full == 2'b00 && g < 500) begin @(negedge clk); g++; end
            t0 = cyc;
            g = 0;
            while (!m_tvalid && g < 50) begin @(negedge clk); g++; end
            chk("latency", 32'(cyc - t0), 32'd2);
         end
      join
      drain();
      chk("err_none", 32'(err_cnt), 32'd0);

      send_block(1'b1, 100, NW, 1'b0, 1'b0, 1'b1);
      drain();

      // Both banks full under backpressure, then three blocks out back to back.
      fix_rdy = 1'b0;
      send_block(1'b0, 200, NW, 1'b0, 1'b0, 1'b1);
      send_block(1'b1, 300, NW, 1'b0, 1'b0, 1'b1);
      repeat (4) cycle();
      chk("both_full", 32'(bank_full), 32'd3);
      chk("stall_ready", 32'(s_tready), 32'd0);
      first_cyc = -1;
      n0 = n_xfer;
      fork
         send_block(1'b0, 400, NW, 1'b0, 1'b0, 1'b1);
         begin
            repeat (3) cycle();
            fix_rdy = 1'b1;
         end
      join
      drain();
      chk("b2b_beats", 32'(n_xfer - n0), 32'd36);
      chk("b2b_span", 32'(last_cyc - first_cyc), 32'd35);

      // Random valid gaps and output backpressure.
      rnd_rdy = 1'b1;
      for (int b = 0; b < 100; b++)
         send_block(1'($urandom_range(0, 1)), 1000 + b * 16, NW, 1'b1, 1'b0, 1'b1);
      drain();
      rnd_rdy = 1'b0;
      fix_rdy = 1'b1;

      e0 = err_cnt;
      send_block(1'b0, 5000, NW, 1'b0, 1'b1, 1'b1);
      drain();
      chk("err_pulses", 32'(err_cnt - e0), 32'd2);

      // Reset mid-stream: 7 beats into a block, 3 beats out of another.
      fix_rdy = 1'b0;
      send_block(1'b1, 6000, NW, 1'b0, 1'b0, 1'b1);
      send_block(1'b0, 6100, 7, 1'b0, 1'b0, 1'b0);
      repeat (2) cycle();
      n0 = n_xfer;
      fix_rdy = 1'b1;
      repeat (3) cycle();
      fix_rdy = 1'b0;
      chk("pre_rst_beats", 32'(n_xfer - n0), 32'd3);
      rst_n = 1'b0;
      cycle();
      chk_reset("mid_rst");
      sb.delete();
      cycle();
      rst_n = 1'b1;
      fix_rdy = 1'b1;
      send_block(1'b0, 7000, NW, 1'b0, 1'b0, 1'b1);
      drain();
      repeat (3) cycle();
      chk("final_idle", 32'(m_tvalid), 32'd0);
   endtask

   initial begin
      run_all();
      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation did not complete, errors=%0d", n_err);
      $fatal(1);
   end
endmodule
